fdiv_sqrt_sched: RTL and testbench
==================================

FDIV_SQRT_SCHED -- requirements
Module: fdiv_sqrt_sched

Interface
REQ-001 SHALL have parameter: TAG_W, 5, width of requester tag.
REQ-002 SHALL have port: clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: req_valid  input  2  per-requester op valid (bit n = requester n).
REQ-005 SHALL have port: req_ready  output  2  per-requester accept.
REQ-006 SHALL have port: req_sqrt  input  2  per-requester op select, 1=sqrt, 0=div.
REQ-007 SHALL have port: req_a  input  66  two packed 33-bit recoded operands A, requester n at [33n+32:33n].
REQ-008 SHALL have port: req_b  input  66  two packed 33-bit recoded operands B, ignored for sqrt.
REQ-009 SHALL have port: req_rm  input  6  two packed 3-bit rounding modes.
REQ-010 SHALL have port: req_tag  input  2*TAG_W  two packed tags.
REQ-011 SHALL have port: flush  input  1  kill any pending or in-flight op.
REQ-012 SHALL have ports to the div/sqrt unit: du_inReady in 1; du_inValid out 1; du_sqrtOp out 1; du_a out 33; du_b out 33; du_rm out 3; du_outValid_div in 1; du_outValid_sqrt in 1; du_exc in 2 {invalid, infinite}.
REQ-013 SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_src out 1 (requester index); rsp_tag out TAG_W; rsp_sqrt out 1; rsp_exc out 2.
REQ-014 SHALL have port: err out 1, watchdog timeout pulse (present only under FDS_WATCHDOG_EN).

Function
REQ-015 SHALL implement FSM IDLE, ISSUE, BUSY, RESP; one op outstanding at a time.
REQ-016 IDLE: req_ready asserted combinationally only for arbitration winner; no req_ready when flush=1 or in any other state.
REQ-017 Arbitration SHALL be round-robin: if both valid, winner = rr pointer; pointer moves to the other requester after every grant; single valid requester always wins.
REQ-018 On grant (valid&ready) SHALL latch src, sqrt, a, b, rm, tag and go ISSUE next cycle.
REQ-019 ISSUE: du_inValid=1 with latched op on du_*; on du_inReady=1 go BUSY; du_inValid low in all other states.
REQ-020 BUSY: completion = du_outValid_sqrt if latched sqrt else du_outValid_div; the other strobe SHALL be ignored; on completion latch du_exc and go RESP.
REQ-021 RESP: rsp_valid=1 with latched src/tag/sqrt/exc, held stable until rsp_ready=1, then IDLE; new grant earliest the cycle after return to IDLE.
REQ-022 Minimum latency: grant cycle 0, du_inValid cycle 1, rsp_valid cycle after completion strobe.
REQ-023 flush in ISSUE SHALL return to IDLE without issuing; flush in RESP SHALL drop response and return to IDLE.
REQ-024 flush in BUSY SHALL set kill flag; op stays BUSY until completion, then IDLE with no rsp_valid; kill cleared on leaving BUSY.
REQ-025 flush and rsp_ready in same RESP cycle: flush wins; no handshake counted.

Reset
REQ-026 reset_n=0 at a rising edge SHALL force IDLE, rr pointer=0, kill=0, all outputs 0 (req_ready, du_inValid, rsp_valid, err, data outputs).
REQ-027 Reset mid-operation SHALL abandon op silently; a late completion strobe in IDLE SHALL be ignored.

Configuration
REQ-028 Macro FDS_WATCHDOG_EN defined: 6-bit counter cleared on entering BUSY, increments each BUSY cycle; reaching 63 SHALL pulse err for one cycle and force IDLE, no response.
REQ-029 FDS_WATCHDOG_EN undefined: no counter, err port absent, BUSY waits indefinitely.

Verification
REQ-030 req_valid=01, div, tag=3, du_inReady=1, completion 10 cycles later -> du_inValid at cycle 1, rsp_valid with rsp_src=0, rsp_tag=3, rsp_sqrt=0.
REQ-031 req_valid=11 held for 4 ops -> grants alternate 0,1,0,1.
REQ-032 sqrt op, du_outValid_div pulses then du_outValid_sqrt -> RESP entered only after sqrt strobe.
REQ-033 flush during BUSY, completion 5 cycles later -> no rsp_valid, IDLE, next request granted.
REQ-034 rsp_ready=0 for 8 cycles in RESP -> rsp_valid and fields stable, req_ready=00 throughout.
REQ-035 With FDS_WATCHDOG_EN, no completion strobe -> err pulse 63 cycles after entering BUSY, then IDLE.

Source files
------------

// File: rtl/fdiv_sqrt_sched.sv
// ---------------------------------------------------------------------------
// fdiv_sqrt_sched
//
// Purpose:
//   Shares one iterative floating-point div/sqrt unit between two requesters.
//   One operation is in flight at a time. A round-robin arbiter picks a
//   winner, the winner's operands are captured and issued to the unit. The
//   scheduler then waits for the completion strobe that matches the
//   operation type and presents a single tagged response.
//
//   flush kills whatever is pending:
//     - before issue, the op is dropped;
//     - while the unit is busy, the op is marked killed and its completion
//       is swallowed;
//     - while a response is waiting, the response is dropped.
//
// Configuration:
//   FDS_WATCHDOG_EN - when defined, a 6-bit busy-cycle counter bounds the
//                     wait for completion. On timeout err pulses for one
//                     cycle and the op is abandoned without a response.
//                     When undefined, the counter and the err port do not
//                     exist, and BUSY waits indefinitely.
//
// Ports:
//   clock, reset_n      rising-edge clock; synchronous active-low reset
//   req_valid/ready     per-requester handshake (bit n = requester n)
//   req_sqrt            per-requester op select (1 = sqrt, 0 = div)
//   req_a/req_b         packed 33-bit recoded operands; requester n uses
//                       [33n+32:33n]. B is ignored for sqrt.
//   req_rm              packed 3-bit rounding modes
//   req_tag             packed TAG_W-bit tags
//   flush               kill any pending or in-flight op
//   du_*                issue/completion interface to the div/sqrt unit
//   rsp_*               response: source index, tag, op type, exceptions
//   err                 watchdog timeout pulse (FDS_WATCHDOG_EN only)
// ---------------------------------------------------------------------------
module fdiv_sqrt_sched #(
  parameter int TAG_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,

  // requester side
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_sqrt,
  input  logic [65:0]        req_a,
  input  logic [65:0]        req_b,
  input  logic [5:0]         req_rm,
  input  logic [2*TAG_W-1:0] req_tag,
  input  logic               flush,

  // div/sqrt unit side
  input  logic               du_inReady,
  output logic               du_inValid,
  output logic               du_sqrtOp,
  output logic [32:0]        du_a,
  output logic [32:0]        du_b,
  output logic [2:0]         du_rm,
  input  logic               du_outValid_div,
  input  logic               du_outValid_sqrt,
  input  logic [1:0]         du_exc,

  // response side
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_src,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_sqrt,
  output logic [1:0]         rsp_exc
`ifdef FDS_WATCHDOG_EN
  ,
  output logic               err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Round-robin pointer: the requester that wins when both are valid.
  logic               r_rr;
  // Set by a flush while the unit is busy; the completion is then swallowed.
  logic               r_kill;

  // Captured operation.
  logic               r_src;
  logic               r_sqrt;
  logic [32:0]        r_a;
  logic [32:0]        r_b;
  logic [2:0]         r_rm;
  logic [TAG_W-1:0]   r_tag;
  logic [1:0]         r_exc;

  logic               w_winner;
  logic               w_grant;
  logic               w_done;
  logic               w_wd_expire;

  logic               w_sel_sqrt;
  logic [32:0]        w_sel_a;
  logic [32:0]        w_sel_b;
  logic [2:0]         w_sel_rm;
  logic [TAG_W-1:0]   w_sel_tag;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_winner = 1'b0;
    case (req_valid)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = r_rr;
      default: w_winner = 1'b0;
    endcase
  end

  // A grant is offered only in IDLE and never while flush is asserted.
  assign w_grant   = (r_state == ST_IDLE) && !flush && (req_valid != 2'b00);
  assign req_ready = w_grant ? (2'b01 << w_winner) : 2'b00;

  // Winner's slice of the packed request buses.
  assign w_sel_sqrt = w_winner ? req_sqrt[1]         : req_sqrt[0];
  assign w_sel_a    = w_winner ? req_a[65:33]        : req_a[32:0];
  assign w_sel_b    = w_winner ? req_b[65:33]        : req_b[32:0];
  assign w_sel_rm   = w_winner ? req_rm[5:3]         : req_rm[2:0];
  assign w_sel_tag  = w_winner ? req_tag[2*TAG_W-1:TAG_W]
                               : req_tag[TAG_W-1:0];

  // Only the strobe matching the issued op type counts as completion; the
  // unit may pulse the other one for its own reasons.
  assign w_done = r_sqrt ? du_outValid_sqrt : du_outValid_div;

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
`ifdef FDS_WATCHDOG_EN
  logic [5:0] r_wd_cnt;
  logic       r_err;

  // The counter holds k in the k-th BUSY cycle (first BUSY cycle is 0). The
  // timeout fires on the edge that takes it to 63, so err is high in the
  // 63rd cycle after entering BUSY, by which point the FSM is back in IDLE.
  assign w_wd_expire = (r_state == ST_BUSY) && (r_wd_cnt == 6'd62) && !w_done;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wd_cnt <= 6'd0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_wd_expire;
      // Held at zero outside BUSY, so it starts from zero on every entry.
      if (r_state != ST_BUSY) begin
        r_wd_cnt <= 6'd0;
      end else if (r_wd_cnt != 6'd63) begin
        r_wd_cnt <= r_wd_cnt + 6'd1;
      end
    end
  end

  assign err = r_err;
`else
  assign w_wd_expire = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: next state and control outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    du_inValid  = 1'b0;
    rsp_valid   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Withdraw the request during a flush so the unit never accepts an
        // op that is being dropped.
        du_inValid = !flush;
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (du_inReady) begin
          w_state_nxt = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // A flush coinciding with completion kills the op like an earlier one.
        if (w_done) begin
          w_state_nxt = (r_kill || flush) ? ST_IDLE : ST_RESP;
        end else if (w_wd_expire) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        // flush and rsp_ready both lead to IDLE; with flush the response is
        // simply dropped rather than handed over.
        if (flush || rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the order of statements does not matter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_rr    <= 1'b0;
      r_kill  <= 1'b0;
      // NOTE: the captured operation is reset too, because it drives the
      // du_* and rsp_* data outputs directly and those read as zero after
      // reset.
      r_src   <= 1'b0;
      r_sqrt  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_rm    <= '0;
      r_tag   <= '0;
      r_exc   <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_grant) begin
        r_rr   <= ~w_winner;
        r_src  <= w_winner;
        r_sqrt <= w_sel_sqrt;
        r_a    <= w_sel_a;
        r_b    <= w_sel_b;
        r_rm   <= w_sel_rm;
        r_tag  <= w_sel_tag;
      end

      // Kill lives only for the duration of one BUSY stay.
      if (r_state == ST_BUSY) begin
        if (w_state_nxt != ST_BUSY) begin
          r_kill <= 1'b0;
        end else if (flush) begin
          r_kill <= 1'b1;
        end
      end else begin
        r_kill <= 1'b0;
      end

      if ((r_state == ST_BUSY) && (w_state_nxt == ST_RESP)) begin
        r_exc <= du_exc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Data outputs straight from the captured operation
  // -------------------------------------------------------------------------
  assign du_sqrtOp = r_sqrt;
  assign du_a      = r_a;
  assign du_b      = r_b;
  assign du_rm     = r_rm;

  assign rsp_src   = r_src;
  assign rsp_tag   = r_tag;
  assign rsp_sqrt  = r_sqrt;
  assign rsp_exc   = r_exc;

endmodule

// File: tb/tb_fdiv_sqrt_sched.sv
// ---------------------------------------------------------------------------
// tb_fdiv_sqrt_sched
//
// Self-checking bench for fdiv_sqrt_sched. The bench plays the div/sqrt unit
// itself (accept delay, completion latency, stray strobes, exception codes)
// and predicts every grant and response from a transaction-level model: a
// round-robin pointer variable plus the captured request fields.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_fdiv_sqrt_sched;

  localparam int TAG_W = 5;

  logic               clock;
  logic               reset_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_sqrt;
  logic [65:0]        req_a;
  logic [65:0]        req_b;
  logic [5:0]         req_rm;
  logic [2*TAG_W-1:0] req_tag;
  logic               flush;
  logic               du_inReady;
  logic               du_inValid;
  logic               du_sqrtOp;
  logic [32:0]        du_a;
  logic [32:0]        du_b;
  logic [2:0]         du_rm;
  logic               du_outValid_div;
  logic               du_outValid_sqrt;
  logic [1:0]         du_exc;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_src;
  logic [TAG_W-1:0]   rsp_tag;
  logic               rsp_sqrt;
  logic [1:0]         rsp_exc;
`ifdef FDS_WATCHDOG_EN
  logic               err;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: which requester wins when both are valid.
  int m_rr = 0;

  fdiv_sqrt_sched #(.TAG_W(TAG_W)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_sqrt         (req_sqrt),
    .req_a            (req_a),
    .req_b            (req_b),
    .req_rm           (req_rm),
    .req_tag          (req_tag),
    .flush            (flush),
    .du_inReady       (du_inReady),
    .du_inValid       (du_inValid),
    .du_sqrtOp        (du_sqrtOp),
    .du_a             (du_a),
    .du_b             (du_b),
    .du_rm            (du_rm),
    .du_outValid_div  (du_outValid_div),
    .du_outValid_sqrt (du_outValid_sqrt),
    .du_exc           (du_exc),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_src          (rsp_src),
    .rsp_tag          (rsp_tag),
    .rsp_sqrt         (rsp_sqrt),
    .rsp_exc          (rsp_exc)
`ifdef FDS_WATCHDOG_EN
    ,
    .err              (err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Round-robin rule: both valid -> pointer; otherwise the lone valid one.
  function automatic int m_winner(input logic [1:0] v);
    if (v == 2'b11) return m_rr;
    if (v[0])       return 0;
    if (v[1])       return 1;
    return -1;
  endfunction

  function automatic logic [65:0] rnd66();
    return 66'({$urandom(), $urandom(), $urandom()});
  endfunction

  // One complete transaction.
  //   stall    : cycles du_inReady is held low in ISSUE
  //   lat      : BUSY cycles up to and including the completion strobe (>=1)
  //   wrong_at : BUSY cycle carrying the non-matching strobe (-1 = none)
  //   rdelay   : cycles rsp_ready is held low in RESP
  //   hold     : keep req_valid asserted until the response is taken
  //   fmode    : 0 none, 1 flush in ISSUE, 2 flush in BUSY, 3 flush in RESP
  task automatic do_txn(input logic [1:0] v, input logic [1:0] sq,
                        input logic [65:0] a, input logic [65:0] b,
                        input logic [5:0] rm, input logic [2*TAG_W-1:0] tg,
                        input int stall, input int lat, input int wrong_at,
                        input int rdelay, input bit hold, input int fmode);
    int               w;
    logic [1:0]       er;
    logic             esrc;
    logic             esq;
    logic [32:0]      ea;
    logic [32:0]      eb;
    logic [2:0]       erm;
    logic [TAG_W-1:0] etg;
    logic [1:0]       eexc;

    w    = m_winner(v);
    er   = (w == 0) ? 2'b01 : 2'b10;
    esrc = 1'(w);
    esq  = sq[w];
    ea   = a[33*w +: 33];
    eb   = b[33*w +: 33];
    erm  = rm[3*w +: 3];
    etg  = tg[TAG_W*w +: TAG_W];
    eexc = 2'($urandom());

    req_valid = v; req_sqrt = sq; req_a = a; req_b = b; req_rm = rm; req_tag = tg;
    #1;
    checks++;
    if (req_ready !== er) begin
      failures++;
      $display("FAIL grant: req_ready=%b expected %b (valid=%b)", req_ready, er, v);
    end
    tick();
    m_rr = 1 - w;
    if (!hold) req_valid = 2'b00;

    if (fmode == 1) begin
      flush = 1'b1; du_inReady = 1'b1;
      #1;
      checks++;
      if (du_inValid !== 1'b0) begin
        failures++;
        $display("FAIL issue_flush: du_inValid=%b expected 0", du_inValid);
      end
      tick();
      flush = 1'b0; du_inReady = 1'b0; req_valid = 2'b00;
      du_outValid_div = 1'b1; du_outValid_sqrt = 1'b1;
      #1;
      checks++;
      if (du_inValid !== 1'b0) begin
        failures++;
        $display("FAIL issue_flush_idle: du_inValid=%b expected 0", du_inValid);
      end
      tick();
      du_outValid_div = 1'b0; du_outValid_sqrt = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL issue_flush_rsp: rsp_valid=%b expected 0", rsp_valid);
      end
      return;
    end

    for (int i = 0; i <= stall; i++) begin
      du_inReady = (i == stall);
      #1;
      checks++;
      if (du_inValid !== 1'b1) begin
        failures++;
        $display("FAIL issue_valid: du_inValid=%b expected 1", du_inValid);
      end
      checks++;
      if ({du_sqrtOp, du_a, du_b, du_rm} !== {esq, ea, eb, erm}) begin
        failures++;
        $display("FAIL issue_op: got sq=%b a=%h b=%h rm=%h expected sq=%b a=%h b=%h rm=%h",
                 du_sqrtOp, du_a, du_b, du_rm, esq, ea, eb, erm);
      end
      checks++;
      if (req_ready !== 2'b00) begin
        failures++;
        $display("FAIL issue_ready: req_ready=%b expected 00", req_ready);
      end
      tick();
    end
    du_inReady = 1'b0;

    for (int i = 0; i < lat; i++) begin
      if (fmode == 2 && i == 0) flush = 1'b1;
      du_outValid_sqrt = (i == lat - 1) ?  esq : ((i == wrong_at) ? !esq : 1'b0);
      du_outValid_div  = (i == lat - 1) ? !esq : ((i == wrong_at) ?  esq : 1'b0);
      du_exc           = (i == lat - 1) ? eexc : 2'($urandom());
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || du_inValid !== 1'b0 || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL busy_quiet: cycle %0d rsp_valid=%b du_inValid=%b req_ready=%b expected 0/0/00",
                 i, rsp_valid, du_inValid, req_ready);
      end
      tick();
      flush = 1'b0;
    end
    du_outValid_sqrt = 1'b0; du_outValid_div = 1'b0; du_exc = ~eexc;

    if (fmode == 2) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL busy_flush_rsp: rsp_valid=%b expected 0", rsp_valid);
      end
      req_valid = 2'b00;
      return;
    end

    for (int i = 0; i <= rdelay; i++) begin
      if (fmode == 3) begin
        flush = 1'b1; rsp_ready = 1'b1;
      end else begin
        rsp_ready = (i == rdelay);
      end
      #1;
      checks++;
      if (rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL rsp_valid: cycle %0d rsp_valid=%b expected 1", i, rsp_valid);
      end
      checks++;
      if ({rsp_src, rsp_tag, rsp_sqrt, rsp_exc} !== {esrc, etg, esq, eexc}) begin
        failures++;
        $display("FAIL rsp_fields: got src=%b tag=%h sqrt=%b exc=%b expected src=%b tag=%h sqrt=%b exc=%b",
                 rsp_src, rsp_tag, rsp_sqrt, rsp_exc, esrc, etg, esq, eexc);
      end
      checks++;
      if (req_ready !== 2'b00) begin
        failures++;
        $display("FAIL rsp_ready_block: req_ready=%b expected 00", req_ready);
      end
      tick();
      flush = 1'b0;
      if (fmode == 3) break;
    end
    rsp_ready = 1'b0; req_valid = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsp_drop: rsp_valid=%b expected 0 after handshake/flush", rsp_valid);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({req_ready, du_inValid, rsp_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL %s_ctrl: req_ready=%b du_inValid=%b rsp_valid=%b expected all 0",
               name, req_ready, du_inValid, rsp_valid);
    end
    checks++;
    if ({du_sqrtOp, du_a, du_b, du_rm} !== '0) begin
      failures++;
      $display("FAIL %s_du: sq=%b a=%h b=%h rm=%h expected 0", name, du_sqrtOp, du_a, du_b, du_rm);
    end
    checks++;
    if ({rsp_src, rsp_tag, rsp_sqrt, rsp_exc} !== '0) begin
      failures++;
      $display("FAIL %s_rsp: src=%b tag=%h sqrt=%b exc=%b expected 0",
               name, rsp_src, rsp_tag, rsp_sqrt, rsp_exc);
    end
`ifdef FDS_WATCHDOG_EN
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL %s_err: err=%b expected 0", name, err);
    end
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = '0; req_sqrt = '0; req_a = '0; req_b = '0; req_rm = '0; req_tag = '0;
    flush = 1'b0; du_inReady = 1'b0; du_outValid_div = 1'b0; du_outValid_sqrt = 1'b0;
    du_exc = '0; rsp_ready = 1'b0;
    tick();
    tick();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    m_rr = 0;
    tick();
  endtask

  task automatic test_basic_div();
    do_txn(2'b01, 2'b00, rnd66(), rnd66(), 6'($urandom()), {5'd9, 5'd3},
           0, 10, -1, 0, 1'b0, 0);
  endtask

  task automatic test_round_robin();
    test_reset();
    for (int i = 0; i < 4; i++)
      do_txn(2'b11, 2'($urandom()), rnd66(), rnd66(), 6'($urandom()),
             10'($urandom()), 0, 2, -1, 0, 1'b1, 0);
  endtask

  task automatic test_sqrt_strobe();
    do_txn(2'b10, 2'b10, rnd66(), rnd66(), 6'($urandom()), 10'($urandom()),
           1, 6, 2, 0, 1'b0, 0);
  endtask

  task automatic test_flush_busy();
    do_txn(2'b01, 2'b00, rnd66(), rnd66(), 6'($urandom()), 10'($urandom()),
           0, 6, -1, 0, 1'b0, 2);
    do_txn(2'b10, 2'b00, rnd66(), rnd66(), 6'($urandom()), 10'($urandom()),
           0, 3, -1, 0, 1'b0, 0);
  endtask

  task automatic test_flush_issue_resp();
    do_txn(2'b01, 2'b01, rnd66(), rnd66(), 6'($urandom()), 10'($urandom()),
           0, 3, -1, 0, 1'b0, 1);
    do_txn(2'b10, 2'b10, rnd66(), rnd66(), 6'($urandom()), 10'($urandom()),
           0, 3, -1, 2, 1'b0, 3);
    do_txn(2'b01, 2'b00, rnd66(), rnd66(), 6'($urandom()), 10'($urandom()),
           0, 1, -1, 0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    do_txn(2'b11, 2'($urandom()), rnd66(), rnd66(), 6'($urandom()), 10'($urandom()),
           0, 4, -1, 8, 1'b1, 0);
  endtask

  task automatic test_reset_mid_op();
    int w;
    req_valid = 2'b01; req_sqrt = 2'b00;
    req_a = rnd66() | 66'd1; req_b = rnd66(); req_rm = 6'h3f; req_tag = 10'h3ff;
    w = m_winner(req_valid);
    #1;
    tick();
    m_rr = 1 - w;
    req_valid = 2'b00;
    du_inReady = 1'b1;
    tick();
    du_inReady = 1'b0;
    reset_n = 1'b0;
    tick();
    check_outputs_zero("midreset");
    reset_n = 1'b1;
    m_rr = 0;
    du_outValid_div = 1'b1; du_outValid_sqrt = 1'b1; du_exc = 2'b11;
    tick();
    du_outValid_div = 1'b0; du_outValid_sqrt = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL late_strobe: rsp_valid=%b expected 0", rsp_valid);
    end
    do_txn(2'b11, 2'($urandom()), rnd66(), rnd66(), 6'($urandom()), 10'($urandom()),
           0, 2, -1, 0, 1'b0, 0);
  endtask

`ifdef FDS_WATCHDOG_EN
  task automatic test_watchdog();
    int w;
    int n;
    req_valid = 2'b01; req_sqrt = 2'b00;
    w = m_winner(req_valid);
    #1;
    tick();
    m_rr = 1 - w;
    req_valid = 2'b00;
    du_inReady = 1'b1;
    tick();
    du_inReady = 1'b0;
    n = -1;
    for (int i = 0; i < 100; i++) begin
      if (err === 1'b1) begin
        n = i;
        break;
      end
      tick();
    end
    checks++;
    if (n != 63) begin
      failures++;
      $display("FAIL wd_latency: err after %0d BUSY cycles expected 63", n);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL wd_rsp: rsp_valid=%b expected 0", rsp_valid);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL wd_pulse: err=%b expected 0 one cycle later", err);
    end
    do_txn(2'b10, 2'b00, rnd66(), rnd66(), 6'($urandom()), 10'($urandom()),
           0, 2, -1, 0, 1'b0, 0);
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [1:0] v;
      int         lat;
      int         fm;
      int         wa;
      v   = 2'($urandom_range(1, 3));
      lat = $urandom_range(1, 6);
      fm  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      if (fm == 2 && lat < 2) lat = 2;
      wa  = (lat >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(0, lat - 2) : -1;
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
          failures++;
          $display("FAIL idle_gap: req_ready=%b expected 00", req_ready);
        end
        tick();
      end
      do_txn(v, 2'($urandom()), rnd66(), rnd66(), 6'($urandom()), 10'($urandom()),
             $urandom_range(0, 2), lat, wa, $urandom_range(0, 3),
             1'($urandom_range(0, 1)), fm);
    end
  endtask

  initial begin
    test_reset();
    test_basic_div();
    test_round_robin();
    test_sqrt_strobe();
    test_flush_busy();
    test_flush_issue_resp();
    test_backpressure();
    test_reset_mid_op();
`ifdef FDS_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
